// File: rtl/rr_stream_arbiter.sv
// ---------------------------------------------------------------------------
// rr_stream_arbiter
//
// Packet-level round-robin arbiter merging N_INPUTS upstream streams into one
// registered downstream stream. A port, once granted, owns the output until
// it delivers a beat with tlast; packets never interleave.
//
// Handshake semantics (both sides): a beat transfers on a rising edge where
// valid and ready are both high. The output side keeps data/last/src stable
// while out_tvalid_o=1 and out_tready_i=0. The output register accepts a new
// beat whenever it is empty or being drained in the same cycle, so a stream
// can move one beat per cycle.
//
// Ports
//   clk_i           clock, rising edge
//   rst_n_i         asynchronous active-low reset
//   in_tdata_i      payloads, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   in_tvalid_i     per-port valid
//   in_tlast_i      per-port end of packet
//   in_tready_o     per-port ready (only the granted port, only in LOCKED)
//   in_half_full_i  upstream queue half-full flags (urgency hint)
//   out_tdata_o     registered payload
//   out_tvalid_o    registered valid
//   out_tlast_o     registered end of packet
//   out_tready_i    downstream ready
//   out_src_o       source port of the beat held in the output register
//   busy_o          high while a packet lock is held
//   dbg_state_o     FSM state (0 = IDLE, 1 = LOCKED)
//
// Build option
//   ARB_URGENT_EN   when defined, ports with valid and half-full set win the
//                   grant decision (round-robin among themselves); when
//                   undefined, in_half_full_i has no effect.
// ---------------------------------------------------------------------------
module rr_stream_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int N_INPUTS   = 4,
   localparam int SRC_W     = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
   input  logic                           clk_i,
   input  logic                           rst_n_i,
   input  logic [N_INPUTS*DATA_WIDTH-1:0] in_tdata_i,
   input  logic [N_INPUTS-1:0]            in_tvalid_i,
   input  logic [N_INPUTS-1:0]            in_tlast_i,
   output logic [N_INPUTS-1:0]            in_tready_o,
   input  logic [N_INPUTS-1:0]            in_half_full_i,
   output logic [DATA_WIDTH-1:0]          out_tdata_o,
   output logic                           out_tvalid_o,
   output logic                           out_tlast_o,
   input  logic                           out_tready_i,
   output logic [SRC_W-1:0]               out_src_o,
   output logic                           busy_o,
   output logic                           dbg_state_o
);

   localparam logic ST_IDLE   = 1'b0;
   localparam logic ST_LOCKED = 1'b1;

   logic                  r_state;
   logic [SRC_W-1:0]      r_grant;
   logic [SRC_W-1:0]      r_last_grant;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic                  r_out_valid;
   logic                  r_out_last;
   logic [SRC_W-1:0]      r_out_src;

   logic                  w_out_free;
   logic                  w_in_hs;
   logic [DATA_WIDTH-1:0] w_sel_data;
   logic                  w_sel_last;
   logic [N_INPUTS-1:0]   w_ready;
   logic [N_INPUTS-1:0]   w_cand;
   logic                  w_any;
   logic [SRC_W-1:0]      w_pick;
   int                    w_idx;

   // Output register can take a beat when empty or draining this cycle.
   assign w_out_free = !r_out_valid || out_tready_i;
   assign w_in_hs    = (r_state == ST_LOCKED) && w_out_free && in_tvalid_i[r_grant];
   assign w_sel_data = in_tdata_i[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
   assign w_sel_last = in_tlast_i[r_grant];

   always_comb begin
      w_ready = '0;
      if ((r_state == ST_LOCKED) && w_out_free) begin
         w_ready[r_grant] = 1'b1;
      end
   end

`ifdef ARB_URGENT_EN
   logic [N_INPUTS-1:0] w_urgent;
   assign w_urgent = in_tvalid_i & in_half_full_i;
   // Urgent ports shadow the rest only when at least one exists.
   assign w_cand   = (|w_urgent) ? w_urgent : in_tvalid_i;
`else
   // Half-full flags are deliberately masked off in this build.
   assign w_cand   = in_tvalid_i | (in_half_full_i & {N_INPUTS{1'b0}});
`endif

   assign w_any = |w_cand;

   // Walk offsets from farthest to nearest so the candidate closest after
   // last_grant is the one that sticks.
   always_comb begin
      w_pick = r_last_grant;
      w_idx  = 0;
      for (int i = N_INPUTS; i >= 1; i--) begin
         w_idx = (int'(r_last_grant) + i) % N_INPUTS;
         if (w_cand[w_idx]) begin
            w_pick = SRC_W'(w_idx);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_last_grant <= SRC_W'(N_INPUTS - 1);
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_grant <= w_pick;
                  r_state <= ST_LOCKED;
               end
            end
            default: begin
               // Lock is held through tvalid gaps; only tlast releases it.
               if (w_in_hs && w_sel_last) begin
                  r_last_grant <= r_grant;
                  r_state      <= ST_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
         r_out_src   <= '0;
      end else if (w_in_hs) begin
         r_out_valid <= 1'b1;
         r_out_last  <= w_sel_last;
         r_out_data  <= w_sel_data;
         r_out_src   <= r_grant;
      end else if (out_tready_i) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_tready_o  = w_ready;
   assign out_tdata_o  = r_out_data;
   assign out_tvalid_o = r_out_valid;
   assign out_tlast_o  = r_out_last;
   assign out_src_o    = r_out_src;
   assign busy_o       = (r_state == ST_LOCKED);
   assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_stream_arbiter
//
// Randomised and directed stimulus for rr_stream_arbiter. Upstream ports are
// fed from per-port beat queues; a behavioural model (lock flag, grant,
// last grant, round-robin search by modular arithmetic, and a one-slot
// expected-output queue) predicts in_tready_o and the output register every
// cycle. Directed sections cover ordering, stalls, valid gaps mid-packet,
// reset mid-packet, urgency selection and sustained throughput.
// ---------------------------------------------------------------------------
module tb_rr_stream_arbiter;

   localparam int DW = 32;
   localparam int N  = 4;
   localparam int SW = 2;
   localparam int BW = SW + 1 + DW;

`ifdef ARB_URGENT_EN
   localparam int URGENT_PICK = 3;
`else
   localparam int URGENT_PICK = 1;
`endif

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   logic rst_n_i;
   always #5 clk_i = ~clk_i;

   logic [N*DW-1:0] in_tdata_i;
   logic [N-1:0]    in_tvalid_i;
   logic [N-1:0]    in_tlast_i;
   logic [N-1:0]    in_tready_o;
   logic [N-1:0]    in_half_full_i;
   logic [DW-1:0]   out_tdata_o;
   logic            out_tvalid_o;
   logic            out_tlast_o;
   logic            out_tready_i;
   logic [SW-1:0]   out_src_o;
   logic            busy_o;
   logic            dbg_state_o;

   rr_stream_arbiter #(.DATA_WIDTH(DW), .N_INPUTS(N)) u_dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .in_tdata_i     (in_tdata_i),
      .in_tvalid_i    (in_tvalid_i),
      .in_tlast_i     (in_tlast_i),
      .in_tready_o    (in_tready_o),
      .in_half_full_i (in_half_full_i),
      .out_tdata_o    (out_tdata_o),
      .out_tvalid_o   (out_tvalid_o),
      .out_tlast_o    (out_tlast_o),
      .out_tready_i   (out_tready_i),
      .out_src_o      (out_src_o),
      .busy_o         (busy_o),
      .dbg_state_o    (dbg_state_o)
   );

   // ---------------- bench state ----------------
   int n_cmp = 0;
   int n_err = 0;

   logic [DW:0]    src_q [N][$];   // {last, data} per upstream port
   logic [BW-1:0]  exp_q [$];      // {src, last, data} expected in output register
   logic [SW-1:0]  seen_src [$];   // sources of beats accepted downstream

   bit        m_locked = 1'b0;
   int        m_grant  = 0;
   int        m_last   = N - 1;

   int        p_valid   = 100;
   int        p_ready   = 100;
   logic [N-1:0] vld_mask = '1;
   bit        hf_rand   = 1'b0;
   logic [N-1:0] hf_force = '0;
   bit        auto_fill = 1'b0;
   int        pkt_id    = 0;
   int        cur_run   = 0;
   int        max_run   = 0;

   // ---------------- scoreboard check ----------------
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic push_pkt(input int port, input int len);
      for (int b = 0; b < len; b++) begin
         src_q[port].push_back({(b == len - 1), 8'(port), 8'(pkt_id), 16'(b)});
      end
      pkt_id++;
   endtask

   function automatic int rr_pick(input logic [N-1:0] cand, input int last);
      for (int d = 1; d <= N; d++) begin
         if (cand[(last + d) % N]) return (last + d) % N;
      end
      return -1;
   endfunction

   // Called just after a rising edge; leaves the bench just after the next.
   task automatic step();
      logic [N-1:0] vld;
      logic [N-1:0] acc;
      logic [N-1:0] cand;
      logic [N-1:0] exp_rdy;
      logic [DW:0]  beat;
      logic [SW-1:0] dut_src;
      bit m_free, in_hs, out_hs, dut_out_hs;
      int pick;

      if (auto_fill) begin
         for (int k = 0; k < N; k++) begin
            if (src_q[k].size() == 0 && $urandom_range(3) == 0) push_pkt(k, $urandom_range(1, 6));
         end
      end
      for (int k = 0; k < N; k++) begin
         vld[k] = (src_q[k].size() != 0) && vld_mask[k] && ($urandom_range(99) < p_valid);
         if (vld[k]) begin
            {in_tlast_i[k], in_tdata_i[k*DW +: DW]} = src_q[k][0];
         end else begin
            in_tdata_i[k*DW +: DW] = $urandom;
            in_tlast_i[k]          = 1'($urandom_range(1));
         end
      end
      in_tvalid_i    = vld;
      in_half_full_i = hf_rand ? N'($urandom) : hf_force;
      out_tready_i   = ($urandom_range(99) < p_ready);
      #1;

      // Model: ready only for the locked port, only if the output slot frees.
      m_free  = (exp_q.size() == 0) || out_tready_i;
      exp_rdy = '0;
      if (m_locked && m_free) exp_rdy[m_grant] = 1'b1;
      check_eq("in_tready", in_tready_o, exp_rdy);

      acc        = vld & in_tready_o;
      dut_out_hs = out_tvalid_o && out_tready_i;
      dut_src    = out_src_o;

      in_hs  = m_locked && m_free && vld[m_grant];
      out_hs = (exp_q.size() != 0) && out_tready_i;
      if (out_hs) void'(exp_q.pop_front());
      if (m_locked) begin
         if (in_hs) begin
            beat = src_q[m_grant][0];
            exp_q.push_back({SW'(m_grant), beat});
            if (beat[DW]) begin
               m_last   = m_grant;
               m_locked = 1'b0;
            end
         end
      end else begin
         cand = vld;
`ifdef ARB_URGENT_EN
         if ((vld & in_half_full_i) != '0) cand = vld & in_half_full_i;
`endif
         pick = rr_pick(cand, m_last);
         if (pick >= 0) begin
            m_locked = 1'b1;
            m_grant  = pick;
         end
      end

      @(posedge clk_i);
      for (int k = 0; k < N; k++) begin
         if (acc[k]) void'(src_q[k].pop_front());
      end
      if (dut_out_hs) seen_src.push_back(dut_src);
      #1;

      cur_run = out_tvalid_o ? cur_run + 1 : 0;
      if (cur_run > max_run) max_run = cur_run;
      check_eq("out_tvalid", out_tvalid_o, exp_q.size() != 0);
      check_eq("busy", busy_o, m_locked);
      if (exp_q.size() != 0) begin
         check_eq("out_tdata", out_tdata_o, exp_q[0][DW-1:0]);
         check_eq("out_tlast", out_tlast_o, exp_q[0][DW]);
         check_eq("out_src", out_src_o, exp_q[0][BW-1 -: SW]);
      end
   endtask

   // Asserts reset away from the clock edge and checks it takes hold at once.
   task automatic do_reset();
      rst_n_i      = 1'b0;
      in_tvalid_i  = '0;
      out_tready_i = 1'b0;
      #1;
      check_eq("rst_out_tvalid", out_tvalid_o, 1'b0);
      check_eq("rst_out_tlast", out_tlast_o, 1'b0);
      check_eq("rst_out_tdata", out_tdata_o, '0);
      check_eq("rst_out_src", out_src_o, '0);
      check_eq("rst_busy", busy_o, 1'b0);
      check_eq("rst_in_tready", in_tready_o, '0);
      exp_q.delete();
      seen_src.delete();
      for (int k = 0; k < N; k++) src_q[k].delete();
      m_locked = 1'b0;
      m_grant  = 0;
      m_last   = N - 1;
      cur_run  = 0;
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int remaining;
      rst_n_i        = 1'b1;
      in_tdata_i     = '0;
      in_tvalid_i    = '0;
      in_tlast_i     = '0;
      in_half_full_i = '0;
      out_tready_i   = 1'b0;
      #2;
      do_reset();

      // Four simultaneous 3-beat packets: grants 0,1,2,3 in order.
      for (int k = 0; k < N; k++) push_pkt(k, 3);
      repeat (20) step();
      check_eq("t1_count", seen_src.size(), 12);
      for (int i = 0; i < seen_src.size(); i++) check_eq("t1_src_order", seen_src[i], i / 3);

      // Port 2, 4 beats, downstream stalled for four cycles.
      seen_src.delete();
      push_pkt(2, 4);
      repeat (3) step();
      p_ready = 0;
      repeat (4) step();
      p_ready = 100;
      repeat (8) step();
      check_eq("t2_count", seen_src.size(), 4);
      for (int i = 0; i < seen_src.size(); i++) check_eq("t2_src", seen_src[i], 2);

      // Port 1 locked, drops valid mid-packet while port 3 waits.
      do_reset();
      push_pkt(1, 4);
      push_pkt(3, 2);
      repeat (2) step();
      vld_mask = 4'b1101;
      repeat (2) begin
         step();
         check_eq("t3_rdy3_blocked", in_tready_o[3], 1'b0);
      end
      vld_mask = '1;
      repeat (12) step();
      check_eq("t3_count", seen_src.size(), 6);
      for (int i = 0; i < seen_src.size(); i++) check_eq("t3_src_order", seen_src[i], (i < 4) ? 1 : 3);

      // Reset during a 5-beat packet, then ports 0 and 1 compete.
      push_pkt(2, 5);
      repeat (3) step();
      do_reset();
      push_pkt(0, 2);
      push_pkt(1, 2);
      repeat (10) step();
      check_eq("t4_count", seen_src.size(), 4);
      for (int i = 0; i < seen_src.size(); i++) check_eq("t4_src_order", seen_src[i], (i < 2) ? 0 : 1);

      // last_grant = 0, ports 1 and 3 valid, half-full on port 3 only.
      do_reset();
      push_pkt(0, 1);
      repeat (4) step();
      seen_src.delete();
      hf_force = 4'b1000;
      push_pkt(1, 2);
      push_pkt(3, 2);
      repeat (10) step();
      check_eq("t5_count", seen_src.size(), 4);
      if (seen_src.size() > 0) check_eq("t5_first_src", seen_src[0], URGENT_PICK);
      hf_force = '0;

      // 16-beat packet with downstream always ready: no bubbles.
      seen_src.delete();
      cur_run = 0;
      max_run = 0;
      push_pkt(0, 16);
      repeat (22) step();
      check_eq("t6_count", seen_src.size(), 16);
      check_eq("t6_max_run", max_run, 16);

      // Random traffic with a reset in the middle, then drain.
      hf_rand   = 1'b1;
      auto_fill = 1'b1;
      p_valid   = 75;
      p_ready   = 60;
      repeat (1500) step();
      do_reset();
      repeat (1500) step();
      auto_fill = 1'b0;
      p_valid   = 100;
      p_ready   = 100;
      repeat (200) step();
      remaining = 0;
      for (int k = 0; k < N; k++) remaining += src_q[k].size();
      check_eq("drain_upstream_empty", remaining, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
